// File: rtl/pipe_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_div_pkg
// Purpose  : Shared types and constants for the EXE-stage iterative divider.
//            Holds the FSM state encoding, the default datapath width and
//            the quotient value returned on a divide by zero.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient reported for x/0 (MIPS leaves it undefined; we return all ones).
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational radix-2 restoring division iteration on
//            unsigned magnitudes.
// Ports    : rem         - partial remainder before this step
//            quo         - partial quotient / remaining dividend bits
//            divisor_mag - divisor magnitude
//            rem_next    - partial remainder after this step
//            quo_next    - quotient after this step (new bit in LSB)
// Revision : 1.0 - initial release
// ============================================================================
module div_step
  import pipe_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // {rem, quo} << 1 : the remainder gains the dividend bit shifted out of quo.
  // Kept at WIDTH+1 bits so the trial subtraction's sign bit is exact.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_mag};

  // Negative trial: restore. The restored value is below divisor_mag, so it
  // always fits back into WIDTH bits.
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/pipe_divider.sv
`default_nettype none
// ============================================================================
// Module   : pipe_divider
// Purpose  : Iterative MIPS DIV/DIVU unit sitting beside the ALU in EXE.
//            Restoring division on magnitudes, one bit per cycle, with a
//            sign fix-up when results are written. Stalls the front end
//            while busy.
// Ports    : clk        - rising-edge clock
//            reset      - synchronous active-low reset
//            start      - DIV/DIVU present in EXE (level)
//            is_signed  - 1 = DIV, 0 = DIVU
//            dividend   - rs operand
//            divisor    - rt operand
//            flush      - synchronous abort
//            stall      - hold IF/ID and ID/EXE registers (combinational)
//            busy       - high while iterating (registered)
//            done       - one-cycle pulse when results update (registered)
//            quotient   - LO result, held
//            remainder  - HI result, held
// Revision : 1.0 - initial release
// ============================================================================
module pipe_divider
  import pipe_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state;
  div_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor_mag;
  logic             sign_q;
  logic             sign_r;

  logic             accept;
  logic             div_by_zero;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign accept      = start && !flush;
  assign div_by_zero = (divisor == '0);
  assign a_neg       = is_signed && dividend[WIDTH-1];
  assign b_neg       = is_signed && divisor[WIDTH-1];

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem         (rem),
    .quo         (quo),
    .divisor_mag (divisor_mag),
    .rem_next    (rem_next),
    .quo_next    (quo_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = div_by_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (flush) begin
          next_state = IDLE;
        end else if (cnt == LAST_STEP) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The pipeline may advance on the DONE cycle, so stall drops there even
  // though start is still high for the same instruction.
  assign stall = (state == RUN) || ((state == IDLE) && accept);

  // Datapath, counter and result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor_mag <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      busy <= (next_state == RUN);
      done <= (next_state == DONE);

      case (state)
        IDLE: begin
          if (accept) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= a_neg ? -dividend : dividend;
            divisor_mag <= b_neg ? -divisor : divisor;
            sign_q      <= a_neg ^ b_neg;
            sign_r      <= a_neg;
            // Divide by zero skips iteration; remainder is the raw rs value.
            if (div_by_zero) begin
              quotient  <= {WIDTH{DIV0_QUOTIENT[0]}};
              remainder <= dividend;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              quotient  <= sign_q ? -quo_next : quo_next;
              remainder <= sign_r ? -rem_next : rem_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_divider
// Purpose  : Directed self-checking bench for pipe_divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_divider;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  int checks   = 0;
  int failures = 0;

  pipe_divider #(
    .WIDTH (WIDTH),
    .CNT_W (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one divide with start held until the done cycle, cycle 0 being the
  // negedge where start is raised. Inputs change at negedge, outputs are
  // sampled 1 time unit later.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input int exp_cyc);
    int done_cyc;
    int stall_bad;
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    flush     = 1'b0;
    start     = 1'b1;
    #1;
    stall_bad = (stall !== 1'b1) ? 1 : 0;
    done_cyc  = -1;
    for (int cyc = 1; cyc <= WIDTH + 8 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) begin
        done_cyc = cyc;
        check({tag, "_stall_at_done"}, {31'd0, stall}, 32'd0);
      end else if (stall !== 1'b1) begin
        stall_bad++;
      end
    end
    check({tag, "_stall_gaps"}, 32'(stall_bad), 32'd0);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, "_quotient"}, quotient, exp_q);
    check({tag, "_remainder"}, remainder, exp_r);
    start = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_done_pulse_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dones;
    reset     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    reset = 1'b1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    run_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    run_div("div_neg_by0", 1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321, 1);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    run_div("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

    // Flush in cycle 10 of a running divide.
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    check("flush_stall_after", {31'd0, stall}, 32'd0);
    flush = 1'b0;
    dones = (done === 1'b1) ? 1 : 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_quotient_held", quotient, 32'd0);
    check("flush_remainder_held", remainder, 32'h8000_0000);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Reset asserted in cycle 5 of a running divide.
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    #1;
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_done", {31'd0, done}, 32'd0);
    check("rst_run_stall", {31'd0, stall}, 32'd0);
    check("rst_run_quotient", quotient, 32'd0);
    check("rst_run_remainder", remainder, 32'd0);
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    check("rst_wins_stall", {31'd0, stall}, 32'd0);
    check("rst_wins_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;

    run_div("divu_after_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_divider.md
Name: pipe_divider

Overview:
- Iterative MIPS DIV/DIVU unit in the EXE stage, beside the ALU.
- Takes operands from the ID/EXE pipeline register and produces LO (quotient) and HI (remainder).
- While dividing, it asserts `stall`. The top level uses `stall` to deassert the `we` of the IF/ID and ID/EXE registers, freezing the front of the pipeline.
- Uses radix-2 restoring division on magnitudes, with a sign fix-up at the end.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low: reset=0 sampled at posedge clears the block.
- start  input  1  EXE holds a DIV/DIVU instruction; level signal from the ID/EXE register.
- is_signed  input  1  1 = DIV, 0 = DIVU.
- dividend  input  WIDTH  rs value.
- divisor  input  WIDTH  rt value.
- flush  input  1  synchronous abort (exception or redirect).
- stall  output  1  combinational; hold the upstream pipe registers.
- busy  output  1  registered; high while in RUN.
- done  output  1  registered; single-cycle pulse when results become valid.
- quotient  output  WIDTH  LO result; registered and held.
- remainder  output  WIDTH  HI result; registered and held.

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0. Reset overrides flush and start.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and flush=0: latch |dividend| and |divisor| (plain values if is_signed=0), sign_q = a[31]^b[31], sign_r = a[31] (signed case only).
  - If divisor==0: go to DONE; else go to RUN with counter=0.
  - start=1 with flush=1: flush wins; stay in IDLE.
- RUN: each cycle performs one restoring step.
  - Form {rem, quo} << 1, then trial = rem - divisor_mag, evaluated at WIDTH+1 bits.
  - If trial is non-negative: rem = trial, quo LSB = 1; else quo LSB = 0.
  - After the WIDTH-th step (counter == WIDTH-1), go to DONE.
- Transition into DONE:
  - quotient <= sign_q ? -quo : quo.
  - remainder <= sign_r ? -rem : rem.
  - done <= 1 for exactly one cycle.
- DONE: start is ignored (it is still high for the same instruction); unconditionally go to IDLE next cycle.
- `stall` = (IDLE and start and !flush) or RUN. It is low in DONE, so the pipeline advances on the DONE cycle.
- Latency, with the start cycle numbered 0:
  - RUN occupies cycles 1..WIDTH.
  - DONE and valid results occur in cycle WIDTH+1 (cycle 33 at default).
  - `stall` is high for cycles 0..WIDTH (33 cycles).
- Divide by zero: no iterations; DONE in cycle 1. quotient = all ones, remainder = dividend (raw, no sign fix-up), for both DIV and DIVU.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This falls out of the magnitude arithmetic; no special case is needed.
- Flush in RUN: go to IDLE next cycle; busy=0; done is not pulsed; quotient and remainder keep their previous values.
- Back-to-back divides: a new start is accepted in the IDLE cycle after DONE.
- quotient and remainder change only on entry to DONE or on reset.

Decomposition:
- Package pipe_div_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH default.
  - DIV0_QUOTIENT = all ones.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor_mag.
  - Outputs: next rem, next quo.
- FSM, counter and sign fix-up stay in pipe_divider.

Test Plan:
- DIVU 100/7, start held high: stall high for cycles 0..32; done only in cycle 33; quotient=14, remainder=2.
- DIV -7/2 (0xFFFFFFF9 / 2): quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7/-2 gives quotient=-3, remainder=1.
- DIVU 0x12345678/0: done in cycle 1; quotient=0xFFFFFFFF, remainder=0x12345678; stall high for cycle 0 only.
- DIV 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0. DIVU of the same operands: quotient=0, remainder=0x80000000.
- Start 100/7, assert flush in cycle 10: busy=0 from cycle 11; no done pulse; quotient and remainder keep prior values. A fresh 9/3 afterwards gives 3/0.
- Assert reset=0 mid-RUN (cycle 5): next cycle all outputs are 0 and state is IDLE. With reset=0, start=1, flush=1 together, reset wins and stall stays 0 next cycle.
